clk_div_sched: RTL
==================

# clk_div_sched

Single-clock programmable clock-divider scheduler. It produces a divided clock-enable waveform and a period tick from `clk_in`. Divide-ratio changes go through a req/ack handshake and are applied only at a period boundary, so the output never glitches or produces a truncated period. It sits between the control/config logic and the fixed-ratio divider consumers, and owns the single shared divide-ratio register.

## Interface
Parameters:
- `CW`, 8, counter and ratio width.
- `DEF_DIV`, 3, ratio loaded at reset. Must satisfy 2 ≤ `DEF_DIV` < 2^CW.

Ports:
- `clk_in`  input  1  sole clock. All logic uses the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  run enable.
- `cfg_req`  input  1  ratio-change request. Held high until `cfg_ack`.
- `cfg_div`  input  CW  requested ratio N. Stable while `cfg_req` is high.
- `cfg_ack`  output  1  one-cycle pulse when the request is applied or rejected.
- `cfg_err`  output  1  one-cycle pulse with `cfg_ack` on an illegal ratio (see Configuration).
- `div_out`  output  1  divided waveform, registered.
- `tick`  output  1  one-cycle pulse on the last cycle of each period, registered.
- `cur_div`  output  CW  active ratio.
- `busy`  output  1  high in PEND.

## Operation
- Reset values:
  - `cur_div`=`DEF_DIV`
  - `count`=0
  - state IDLE
  - `div_out`=0, `tick`=0, `cfg_ack`=0, `cfg_err`=0, `busy`=0
  - latched request discarded
- States:
  - IDLE: count held at 0; `div_out`=0, `tick`=0.
  - RUN: counting.
  - PEND: counting, with a latched new ratio waiting for the boundary.
- Per-cycle behaviour in RUN/PEND:
  - `div_out` = (count < `cur_div`>>1).
  - `tick` = (count == `cur_div`-1).
  - count wraps to 0 after `cur_div`-1.
  - N=3 gives `div_out` 1,0,0 and `tick` 0,0,1.
- Transitions:
  - IDLE→RUN when `en`=1. The first RUN cycle has count=0.
  - IDLE with `cfg_req`: `cfg_div` is applied to `cur_div` and `cfg_ack` pulses on the next cycle. No period is in progress, so there is no wait.
  - RUN→PEND on `cfg_req`: `cfg_div` is latched that cycle.
  - PEND: `cfg_req` is ignored. At the boundary (the cycle with `tick`=1):
    - `cur_div` takes the latched value.
    - `cfg_ack` pulses in that same cycle.
    - The next period uses the new N, starting at count=0.
  - RUN/PEND with `en`=0: the current period completes. At its boundary the state goes to IDLE, and any PEND request is applied and acked there.
- Handshake:
  - The requester drops `cfg_req` in the cycle after `cfg_ack`.
  - `cfg_req` still high in the cycle after ack is taken as a new request.
- Simultaneous events:
  - `cfg_req` arriving in a RUN `tick` cycle is latched. It is applied at the next boundary, not the current one.
  - `rst` overrides everything.
- Reset mid-operation, including during PEND: the latched request is dropped and no ack is issued. The requester retries.
- Arithmetic: count is CW bits wide. No wrap past `cur_div`-1 is possible because `cur_div` ≥ 2.

## Timing
- Request-to-ack latency:
  - IDLE: 1 cycle.
  - RUN/PEND: until the current period boundary, at most the old N cycles.
- The period immediately following an ack has exactly the new N cycles. There are never partial periods.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro `CLKDIV_RATIO_CHECK_EN`.
- Defined: a request with `cfg_div` < 2 is rejected.
  - `cur_div` is unchanged.
  - `cfg_ack` and `cfg_err` pulse together at the normal ack time.
- Undefined: `cfg_div` < 2 is clamped to 2 and acked normally. `cfg_err` is tied to 0.
- In both cases the port list is identical.

## Test plan
- Reset, then `en`=1 with `DEF_DIV`=3 → `tick` every 3rd cycle, `div_out` pattern 1,0,0 repeating, `cur_div`=3.
- While running N=3, assert `cfg_req` with `cfg_div`=5 when count=1 → `busy`=1, `cfg_ack` on the count=2 cycle. The next period is 5 cycles with `div_out` 1,1,0,0,0.
- Drop `en` when count=0 with N=4 → the period completes (4 cycles, `tick` on the last), then IDLE with `div_out`=0. Re-assert `en` → restart at count=0.
- `cfg_req` with `cfg_div`=1 in IDLE:
  - With the macro: `cfg_ack`=`cfg_err`=1 one cycle later, `cur_div`=3.
  - Without the macro: `cfg_ack`=1, `cur_div`=2.
- Assert `rst` during PEND (request N=7) → no `cfg_ack`, `cur_div`=3, IDLE, all outputs at reset values.
- `cfg_req` with `cfg_div`=6 in the RUN `tick` cycle with N=3 → applied at the following boundary, 3 cycles later. The next period is 6 cycles.

Source files
------------

// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - programmable clock-divider scheduler with boundary-aligned ratio changes
// Optional macro CLKDIV_RATIO_CHECK_EN: reject ratios below 2 instead of clamping them.
module clk_div_sched #(
    parameter int CW      = 8,
    parameter int DEF_DIV = 3
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          en,
    input  logic          cfg_req,
    input  logic [CW-1:0] cfg_div,
    output logic          cfg_ack,
    output logic          cfg_err,
    output logic          div_out,
    output logic          tick,
    output logic [CW-1:0] cur_div,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] TWO = CW'(2);
    localparam logic [CW-1:0] DEF = CW'(DEF_DIV);

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic [CW-1:0] cur_div_n, last_n;
    logic [CW-1:0] pend_div, pend_div_n;
    logic          pend_bad, pend_bad_n;
    logic [CW-1:0] req_div;
    logic          req_bad, req_v, tick_now, ack_n, err_n;

    always_comb begin
`ifdef CLKDIV_RATIO_CHECK_EN
        req_bad = (cfg_div < TWO);
        req_div = cfg_div;
`else
        req_bad = 1'b0;
        req_div = (cfg_div < TWO) ? TWO : cfg_div;
`endif
    end

    always_comb begin
        // The requester still holds cfg_req during the ack cycle; that is not a new request.
        req_v      = cfg_req && !cfg_ack;
        tick_now   = (count == cur_div - ONE);
        state_n    = state;
        count_n    = count;
        cur_div_n  = cur_div;
        pend_div_n = pend_div;
        pend_bad_n = pend_bad;
        ack_n      = 1'b0;
        err_n      = 1'b0;
        case (state)
            IDLE: begin
                count_n = '0;
                if (req_v) begin
                    if (!req_bad) begin
                        cur_div_n = req_div;
                    end
                    ack_n = 1'b1;
                    err_n = req_bad;
                end
                if (en) begin
                    state_n = RUN;
                end
            end
            default: begin
                if (tick_now) begin
                    count_n = '0;
                    if (state == PEND && !pend_bad) begin
                        cur_div_n = pend_div;
                    end
                    if (!en) begin
                        state_n = IDLE;
                    end else if (req_v) begin
                        state_n    = PEND;
                        pend_div_n = req_div;
                        pend_bad_n = req_bad;
                    end else begin
                        state_n = RUN;
                    end
                end else begin
                    count_n = count + ONE;
                    if (state == RUN && req_v) begin
                        state_n    = PEND;
                        pend_div_n = req_div;
                        pend_bad_n = req_bad;
                    end
                end
            end
        endcase
        last_n = cur_div_n - ONE;
        // Pending requests are acked in the boundary cycle, so decode it one cycle ahead.
        if (state_n == PEND && count_n == last_n) begin
            ack_n = 1'b1;
            err_n = pend_bad_n;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            cur_div  <= DEF;
            pend_div <= '0;
            pend_bad <= 1'b0;
            div_out  <= 1'b0;
            tick     <= 1'b0;
            cfg_ack  <= 1'b0;
            cfg_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            cur_div  <= cur_div_n;
            pend_div <= pend_div_n;
            pend_bad <= pend_bad_n;
            div_out  <= (state_n != IDLE) && (count_n < (cur_div_n >> 1));
            tick     <= (state_n != IDLE) && (count_n == last_n);
            cfg_ack  <= ack_n;
            cfg_err  <= err_n;
            busy     <= (state_n == PEND);
        end
    end

endmodule
